h2c_cfg_demux: RTL
==================

# h2c_cfg_demux

Packet demultiplexer between the QDMA H2C stream and the programmable packet pipeline. It classifies each packet on its first beat as either a pipeline configuration packet or a data packet, then steers the whole packet to the matching AXI-Stream output. A single registered output stage gives full throughput. Optional per-class packet counters are included.

## Interface
Parameters:
- DATA_WIDTH, 512: stream data width in bits; must be ≥ 512 so headers fit in the first beat.
- CFG_UDP_PORT, 16'hF1F2: UDP destination port that marks a configuration packet.

Ports:
- axis_aclk  in  1  single clock; all logic on rising edge.
- axis_rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  input data; byte 0 in bits [7:0].
- s_axis_tuser_mty  in  6  empty bytes on the last beat.
- s_axis_tvalid, s_axis_tlast  in  1 each  input handshake and end of packet.
- s_axis_tready  out  1  input ready.
- m_axis_data_tdata / _tuser_mty / _tvalid / _tlast  out  DATA_WIDTH/6/1/1  data-packet output.
- m_axis_data_tready  in  1
- m_axis_cfg_tdata / _tuser_mty / _tvalid / _tlast  out  DATA_WIDTH/6/1/1  configuration-packet output.
- m_axis_cfg_tready  in  1
- cfg_pkt_cnt, data_pkt_cnt  out  32 each  accepted-packet counters.

## Operation
- States: SOP (next accepted beat is a first beat) and BODY (inside a packet).
- **Classification** happens on the SOP beat. A packet is config iff all of these byte checks pass (network byte order, MSB at the lower byte index); otherwise it is data:
  - bytes 12–13 = 0x8100
  - bytes 16–17 = 0x0800
  - byte 27 = 0x11
  - bytes 40–41 = CFG_UDP_PORT
- The route is latched on the SOP beat and held for every beat through tlast.
- **Transitions:**
  - SOP beat accepted with tlast=0 → BODY.
  - Beat accepted with tlast=1 → SOP, including single-beat packets.
- **Output stage:** one register per output; only the routed output's tvalid is asserted. The other output's tvalid stays 0 and its data is don't-care.
- s_axis_tready = ~out_valid | ready_of_routed_output, where out_valid is the tvalid of the occupied output register. This gives full throughput and no combinational path from tvalid to tready.
- Data, mty and tlast pass through unmodified.
- **Counters:** each counter increments by 1 when the SOP beat of its class is accepted. Counters wrap from 0xFFFFFFFF to 0.
- **Reset:**
  - All tvalid = 0 and state = SOP; counters = 0; data/mty/tlast registers = 0.
  - Reset mid-packet discards the buffered beat. The next accepted beat is classified as a new SOP.
- Backpressure on the unused output has no effect.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on its output after edge N.
- An output holds tdata/tlast/mty stable while tvalid=1 and its tready=0.
- Output valid and ready both high with input valid → new beat is loaded on the same edge (no bubble).
- Counter value is visible the cycle after the SOP handshake.
- s_axis_tready is 0 while axis_rst=1 and is 1 in the first cycle after reset.

## Configuration
- CFG_DEMUX_STATS_EN:
  - Defined: cfg_pkt_cnt and data_pkt_cnt are implemented as above.
  - Undefined: both outputs are tied to 32'h0 and no counter flops are synthesized.
- Routing behaviour is identical in both cases.

## Test plan
- **VLAN/IPv4/UDP, dport 0xF1F2, 3 beats (last mty=6'd10), both readies=1** → 3 beats on m_axis_cfg, data tvalid never 1, cfg_pkt_cnt=1.
- **Single-beat data packet, VLAN VID 1, dport 0x04D2** → one m_axis_data beat one cycle later with identical tdata, tlast=1; data_pkt_cnt=1.
- **m_axis_data_tready=0 for 5 cycles during a 4-beat data packet** → beats held stable, none lost or duplicated, s_axis_tready low while the register is full; total 4 output beats.
- **Config packet followed back-to-back by a data packet, readies=1** → no idle cycle; outputs switch at the packet boundary; counters 1/1.
- **axis_rst pulsed during beat 2 of a 4-beat packet** → all tvalid=0 next cycle; the next beat is classified as SOP by its own header; counters=0.
- **Counter preloaded to 0xFFFFFFFF via force, one more config packet** (stats build) → cfg_pkt_cnt=0. Non-stats build → both counters read 0 throughout.

Source files
------------

// File: rtl/h2c_cfg_demux.sv
// H2C stream demux: classifies each packet on its first beat and steers it to the
// config or data AXI-Stream output. Optional per-class counters under CFG_DEMUX_STATS_EN.
module h2c_cfg_demux #(
  parameter int          DATA_WIDTH   = 512,
  parameter logic [15:0] CFG_UDP_PORT = 16'hF1F2
) (
  input  logic                  axis_aclk,
  input  logic                  axis_rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [5:0]            s_axis_tuser_mty,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
  output logic [5:0]            m_axis_data_tuser_mty,
  output logic                  m_axis_data_tvalid,
  output logic                  m_axis_data_tlast,
  input  logic                  m_axis_data_tready,
  output logic [DATA_WIDTH-1:0] m_axis_cfg_tdata,
  output logic [5:0]            m_axis_cfg_tuser_mty,
  output logic                  m_axis_cfg_tvalid,
  output logic                  m_axis_cfg_tlast,
  input  logic                  m_axis_cfg_tready,
  output logic [31:0]           cfg_pkt_cnt,
  output logic [31:0]           data_pkt_cnt
);

  // state   | meaning
  // ST_SOP  | next accepted beat is the first beat of a packet
  // ST_BODY | inside a packet; route held from its first beat
  typedef enum logic {ST_SOP = 1'b0, ST_BODY = 1'b1} state_e;

  state_e                state_q, state_d;
  logic                  route_cfg_q, route_cfg_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_cfg_q, out_cfg_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [5:0]            out_mty_q, out_mty_d;
  logic                  out_last_q, out_last_d;

  logic is_cfg_hdr;
  logic out_ready;
  logic beat_acc;
  logic sop_beat;
  logic beat_is_cfg;

  // VLAN(0x8100) / IPv4(0x0800) / UDP(0x11) / configured destination port
  always_comb begin
    is_cfg_hdr = (s_axis_tdata[12*8 +: 8] == 8'h81) &&
                 (s_axis_tdata[13*8 +: 8] == 8'h00) &&
                 (s_axis_tdata[16*8 +: 8] == 8'h08) &&
                 (s_axis_tdata[17*8 +: 8] == 8'h00) &&
                 (s_axis_tdata[27*8 +: 8] == 8'h11) &&
                 (s_axis_tdata[40*8 +: 8] == CFG_UDP_PORT[15:8]) &&
                 (s_axis_tdata[41*8 +: 8] == CFG_UDP_PORT[7:0]);
  end

  assign out_ready     = out_cfg_q ? m_axis_cfg_tready : m_axis_data_tready;
  assign s_axis_tready = ~axis_rst & (~out_valid_q | out_ready);
  assign beat_acc      = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) state_q <= ST_SOP;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SOP:  if (beat_acc && !s_axis_tlast) state_d = ST_BODY;
      ST_BODY: if (beat_acc && s_axis_tlast)  state_d = ST_SOP;
      default: state_d = ST_SOP;
    endcase
  end

  always_comb begin
    sop_beat    = (state_q == ST_SOP);
    beat_is_cfg = sop_beat ? is_cfg_hdr : route_cfg_q;
    route_cfg_d = (beat_acc && sop_beat) ? is_cfg_hdr : route_cfg_q;
  end

  // Shared output register; the route bit selects which tvalid it drives.
  always_comb begin
    out_valid_d = out_valid_q;
    out_cfg_d   = out_cfg_q;
    out_data_d  = out_data_q;
    out_mty_d   = out_mty_q;
    out_last_d  = out_last_q;
    if (beat_acc) begin
      out_valid_d = 1'b1;
      out_cfg_d   = beat_is_cfg;
      out_data_d  = s_axis_tdata;
      out_mty_d   = s_axis_tuser_mty;
      out_last_d  = s_axis_tlast;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      route_cfg_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_cfg_q   <= 1'b0;
      out_data_q  <= '0;
      out_mty_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      route_cfg_q <= route_cfg_d;
      out_valid_q <= out_valid_d;
      out_cfg_q   <= out_cfg_d;
      out_data_q  <= out_data_d;
      out_mty_q   <= out_mty_d;
      out_last_q  <= out_last_d;
    end
  end

  assign m_axis_data_tvalid    = out_valid_q & ~out_cfg_q;
  assign m_axis_data_tdata     = out_data_q;
  assign m_axis_data_tuser_mty = out_mty_q;
  assign m_axis_data_tlast     = out_last_q;
  assign m_axis_cfg_tvalid     = out_valid_q & out_cfg_q;
  assign m_axis_cfg_tdata      = out_data_q;
  assign m_axis_cfg_tuser_mty  = out_mty_q;
  assign m_axis_cfg_tlast      = out_last_q;

`ifdef CFG_DEMUX_STATS_EN
  logic [31:0] cfg_pkt_cnt_q, cfg_pkt_cnt_d;
  logic [31:0] data_pkt_cnt_q, data_pkt_cnt_d;

  always_comb begin
    cfg_pkt_cnt_d  = cfg_pkt_cnt_q;
    data_pkt_cnt_d = data_pkt_cnt_q;
    if (beat_acc && sop_beat) begin
      if (is_cfg_hdr) cfg_pkt_cnt_d  = cfg_pkt_cnt_q + 32'd1;
      else            data_pkt_cnt_d = data_pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      cfg_pkt_cnt_q  <= '0;
      data_pkt_cnt_q <= '0;
    end else begin
      cfg_pkt_cnt_q  <= cfg_pkt_cnt_d;
      data_pkt_cnt_q <= data_pkt_cnt_d;
    end
  end

  assign cfg_pkt_cnt  = cfg_pkt_cnt_q;
  assign data_pkt_cnt = data_pkt_cnt_q;
`else
  assign cfg_pkt_cnt  = 32'h0;
  assign data_pkt_cnt = 32'h0;
`endif

endmodule
